bist_sequencer: RTL and testbench
=================================

Name: bist_sequencer

Overview:
- Top-level controller for the memory BIST engine.
- On a START request it runs the BIST engine through each enabled pattern mode in a fixed order: LFSR (001), then Gray (010), then Binary (100).
- For each mode it holds BIST_EN for a programmed number of 4-cycle write/read iterations, then drains the engine back to IDLE.
- It counts compare failures, captures the first failing mode and address for the BISR repair logic, and reports DONE/PASS to the memory controller.

Parameters:
- ITER_CNT, 1024: write/read iterations per mode; each iteration is 4 cycles.
- CNT_W, 16: width of the run-cycle counter; must hold ITER_CNT*4-1.
- DRAIN_CYC, 4: cycles BIST_EN is held low between modes, so the engine returns to IDLE and its last compare lands.
- FAIL_CNT_W, 16: width of the saturating failure counter.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- START  in  1  single-cycle request to start a test sequence
- ABORT  in  1  terminates an active sequence
- MODE_EN  in  3  enabled modes; bit0=LFSR, bit1=Gray, bit2=Binary
- BIST_FAIL_VALID  in  1  engine compare strobe
- BIST_FAIL  in  1  compare mismatch; qualified by BIST_FAIL_VALID
- BIST_FAIL_ADDR  in  16  {ODATA_SELECT[5:0], ADDR[9:0]} of the compared location
- BIST_EN  out  1  engine enable
- BIST_MODE  out  3  one-hot engine mode
- BUSY  out  1  sequence active
- DONE  out  1  one-cycle completion pulse
- PASS  out  1  result; valid from DONE until the next accepted START
- ABORTED  out  1  last sequence was aborted
- FAIL_CNT  out  FAIL_CNT_W  saturating failure count
- FIRST_FAIL_MODE  out  3  mode active at the first failure
- FIRST_FAIL_ADDR  out  16  address of the first failure

Behaviour:
- One clock, CLK. Reset RST is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, all counters 0.
- States: IDLE, RUN, DRAIN, FINISH. All outputs are registered.

IDLE:
- BIST_EN=0, BIST_MODE=0, BUSY=0.
- START with MODE_EN!=0 and ABORT=0:
  - clear FAIL_CNT, FIRST_FAIL_*, PASS, ABORTED;
  - load cur_mode = lowest set bit of MODE_EN; latch MODE_EN internally;
  - go to RUN.
- START with MODE_EN==0: go to FINISH; PASS=1 at DONE.
- START together with ABORT: ignored; stay IDLE.

RUN:
- BIST_EN=1, BIST_MODE=cur_mode, BUSY=1.
- Cycle counter runs 0..ITER_CNT*4-1. At the terminal count go to DRAIN and reset the counter.

DRAIN:
- BIST_EN=0, BIST_MODE held at cur_mode, BUSY=1.
- After DRAIN_CYC cycles:
  - if a higher enabled mode remains in the latched mask, set cur_mode to it and go to RUN;
  - otherwise go to FINISH.

FINISH:
- DONE=1 for exactly one cycle; BIST_EN=0; BIST_MODE=0.
- PASS = (FAIL_CNT==0) & ~ABORTED. Then go to IDLE.

ABORT:
- In RUN or DRAIN: next cycle BIST_EN=0, BIST_MODE=0, ABORTED=1, go to FINISH. PASS is forced 0.
- In IDLE or FINISH: ignored.

Failure capture:
- Active in RUN and DRAIN only. A failure event is BIST_FAIL_VALID & BIST_FAIL in the same cycle.
- FAIL_CNT increments by 1 per event and saturates at all-ones.
- On the first event of a sequence (FAIL_CNT==0), capture FIRST_FAIL_MODE=cur_mode and FIRST_FAIL_ADDR=BIST_FAIL_ADDR.
- Later events never overwrite the capture.

Other rules:
- START while BUSY is ignored.
- MODE_EN changes during a sequence are ignored; the latched mask is used.
- Reset mid-sequence: next cycle all outputs 0 and state IDLE. No DONE pulse.
- Results (PASS, ABORTED, FAIL_CNT, FIRST_FAIL_*) are held stable in IDLE until the next accepted START.

Test Plan:
(ITER_CNT=4, DRAIN_CYC=4 unless stated.)
1. START with MODE_EN=3'b111, no failures -> BIST_EN high 16 cycles per mode; BIST_MODE sequence 001, 010, 100 with 4-cycle low gaps between modes; DONE pulses 61 cycles after START is sampled; PASS=1, FAIL_CNT=0, ABORTED=0.
2. MODE_EN=3'b010 -> only BIST_MODE=010 is driven; DONE 21 cycles after START; MODE_EN=3'b000 -> DONE the next cycle with PASS=1.
3. Failure events in mode 010 at addr 16'h0C05, then 16'h0C09, then one in mode 100 at 16'h1234, plus one BIST_FAIL without VALID -> FAIL_CNT=3, FIRST_FAIL_MODE=3'b010, FIRST_FAIL_ADDR=16'h0C05, PASS=0.
4. ABORT on the 5th RUN cycle of mode 001 -> next cycle BIST_EN=0 and BIST_MODE=0, then one DONE pulse with PASS=0, ABORTED=1; a following START is accepted and clears ABORTED.
5. FAIL_CNT_W=4 with 20 failure events -> FAIL_CNT=4'hF with no wrap; PASS=0.
6. RST asserted mid-RUN -> next cycle every output is 0 and no DONE pulse; START asserted while BUSY does not restart the counter or change cur_mode.

Source files
------------

// File: rtl/bist_sequencer.sv
// Memory BIST sequencer: steps the engine through the enabled pattern modes (LFSR, Gray, Binary),
// counts compare failures, captures the first failing mode/address and reports DONE/PASS.
module bist_sequencer #(
    parameter int ITER_CNT   = 1024,
    parameter int CNT_W      = 16,
    parameter int DRAIN_CYC  = 4,
    parameter int FAIL_CNT_W = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  ABORT,
    input  logic [2:0]            MODE_EN,
    input  logic                  BIST_FAIL_VALID,
    input  logic                  BIST_FAIL,
    input  logic [15:0]           BIST_FAIL_ADDR,
    output logic                  BIST_EN,
    output logic [2:0]            BIST_MODE,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  PASS,
    output logic                  ABORTED,
    output logic [FAIL_CNT_W-1:0] FAIL_CNT,
    output logic [2:0]            FIRST_FAIL_MODE,
    output logic [15:0]           FIRST_FAIL_ADDR
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(ITER_CNT * 4 - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2:0]              cur_mode_q, cur_mode_d;
    logic [2:0]              mask_q, mask_d;
    logic                    bist_en_q, bist_en_d;
    logic [2:0]              bist_mode_q, bist_mode_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    pass_q, pass_d;
    logic                    aborted_q, aborted_d;
    logic [FAIL_CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic [2:0]              ff_mode_q, ff_mode_d;
    logic [15:0]             ff_addr_q, ff_addr_d;
    logic                    fail_ev_s;
    logic [2:0]              next_mode_s;

    function automatic logic [2:0] lowest_mode(input logic [2:0] m);
        logic [2:0] r;
        if (m[0])      r = 3'b001;
        else if (m[1]) r = 3'b010;
        else if (m[2]) r = 3'b100;
        else           r = 3'b000;
        return r;
    endfunction

    // Next enabled mode strictly above the current one; zero when none remain.
    function automatic logic [2:0] higher_mode(input logic [2:0] m, input logic [2:0] cur);
        logic [2:0] r;
        case (cur)
            3'b001: begin
                if (m[1])      r = 3'b010;
                else if (m[2]) r = 3'b100;
                else           r = 3'b000;
            end
            3'b010: begin
                if (m[2]) r = 3'b100;
                else      r = 3'b000;
            end
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    assign fail_ev_s   = BIST_FAIL_VALID & BIST_FAIL & ((state_q == S_RUN) | (state_q == S_DRAIN));
    assign next_mode_s = higher_mode(mask_q, cur_mode_q);

    // Next-state, output and result-capture logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_mode_d  = cur_mode_q;
        mask_d      = mask_q;
        bist_en_d   = 1'b0;
        bist_mode_d = 3'b000;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        pass_d      = pass_q;
        aborted_d   = aborted_q;
        fail_cnt_d  = fail_cnt_q;
        ff_mode_d   = ff_mode_q;
        ff_addr_d   = ff_addr_q;

        case (state_q)
            S_IDLE: begin
                if (START && !ABORT) begin
                    fail_cnt_d = '0;
                    ff_mode_d  = 3'b000;
                    ff_addr_d  = 16'h0000;
                    pass_d     = 1'b0;
                    aborted_d  = 1'b0;
                    cnt_d      = '0;
                    mask_d     = MODE_EN;
                    cur_mode_d = lowest_mode(MODE_EN);
                    if (MODE_EN != 3'b000) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_FINISH;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                busy_d = 1'b1;
                if (ABORT) begin
                    aborted_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_FINISH;
                end else begin
                    bist_en_d   = 1'b1;
                    bist_mode_d = cur_mode_q;
                    if (cnt_q == RUN_LAST) begin
                        cnt_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                busy_d = 1'b1;
                if (ABORT) begin
                    aborted_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_FINISH;
                end else begin
                    bist_mode_d = cur_mode_q;
                    if (cnt_q == DRAIN_LAST) begin
                        cnt_d = '0;
                        if (next_mode_s != 3'b000) begin
                            cur_mode_d = next_mode_s;
                            state_d    = S_RUN;
                        end else begin
                            state_d = S_FINISH;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                pass_d  = (fail_cnt_q == '0) & ~aborted_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (fail_ev_s) begin
            if (fail_cnt_q != '1) begin
                fail_cnt_d = fail_cnt_q + FAIL_CNT_W'(1);
            end else begin
                fail_cnt_d = fail_cnt_q;
            end
            if (fail_cnt_q == '0) begin
                ff_mode_d = cur_mode_q;
                ff_addr_d = BIST_FAIL_ADDR;
            end else begin
                ff_mode_d = ff_mode_q;
                ff_addr_d = ff_addr_q;
            end
        end else begin
            fail_cnt_d = fail_cnt_d;
        end
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cur_mode_q  <= 3'b000;
            mask_q      <= 3'b000;
            bist_en_q   <= 1'b0;
            bist_mode_q <= 3'b000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            aborted_q   <= 1'b0;
            fail_cnt_q  <= '0;
            ff_mode_q   <= 3'b000;
            ff_addr_q   <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_mode_q  <= cur_mode_d;
            mask_q      <= mask_d;
            bist_en_q   <= bist_en_d;
            bist_mode_q <= bist_mode_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            aborted_q   <= aborted_d;
            fail_cnt_q  <= fail_cnt_d;
            ff_mode_q   <= ff_mode_d;
            ff_addr_q   <= ff_addr_d;
        end
    end

    assign BIST_EN         = bist_en_q;
    assign BIST_MODE       = bist_mode_q;
    assign BUSY            = busy_q;
    assign DONE            = done_q;
    assign PASS            = pass_q;
    assign ABORTED         = aborted_q;
    assign FAIL_CNT        = fail_cnt_q;
    assign FIRST_FAIL_MODE = ff_mode_q;
    assign FIRST_FAIL_ADDR = ff_addr_q;

endmodule

// File: tb/tb_bist_sequencer.sv
// Directed bench for bist_sequencer with ITER_CNT=4, DRAIN_CYC=4 and a 4-bit failure counter.
module tb_bist_sequencer;

    logic        CLK = 1'b0;
    logic        RST, START, ABORT, BIST_FAIL_VALID, BIST_FAIL;
    logic [2:0]  MODE_EN;
    logic [15:0] BIST_FAIL_ADDR;
    logic        BIST_EN, BUSY, DONE, PASS, ABORTED;
    logic [2:0]  BIST_MODE, FIRST_FAIL_MODE;
    logic [3:0]  FAIL_CNT;
    logic [15:0] FIRST_FAIL_ADDR;

    int checks = 0;
    int errors = 0;

    bist_sequencer #(.ITER_CNT(4), .CNT_W(16), .DRAIN_CYC(4), .FAIL_CNT_W(4)) dut (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .MODE_EN(MODE_EN),
        .BIST_FAIL_VALID(BIST_FAIL_VALID), .BIST_FAIL(BIST_FAIL), .BIST_FAIL_ADDR(BIST_FAIL_ADDR),
        .BIST_EN(BIST_EN), .BIST_MODE(BIST_MODE), .BUSY(BUSY), .DONE(DONE), .PASS(PASS),
        .ABORTED(ABORTED), .FAIL_CNT(FAIL_CNT), .FIRST_FAIL_MODE(FIRST_FAIL_MODE),
        .FIRST_FAIL_ADDR(FIRST_FAIL_ADDR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  mode_en;
        int          fail_at;
        int          fail_n;
        int          abort_at;
        int          busy_start_at;
        int          exp_done;
        int          exp_en;
        logic [8:0]  exp_seq;
        logic        exp_pass;
        logic        exp_aborted;
        logic [3:0]  exp_fcnt;
        logic [2:0]  exp_ffmode;
        logic [15:0] exp_ffaddr;
    } scn_t;

    scn_t tbl[7];

    int          obs_done_cyc, obs_done_n, obs_en_n;
    logic [8:0]  obs_seq;
    logic [2:0]  last_mode;
    logic        obs_pass, obs_aborted;
    logic [3:0]  obs_fcnt;
    logic [2:0]  obs_ffmode;
    logic [15:0] obs_ffaddr;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_scn(input int idx, input scn_t s);
        obs_done_cyc = -1; obs_done_n = 0; obs_en_n = 0; obs_seq = 9'd0; last_mode = 3'b000;
        obs_pass = 1'b0; obs_aborted = 1'b0; obs_fcnt = 4'h0; obs_ffmode = 3'b000; obs_ffaddr = 16'h0;
        START = 1'b1; MODE_EN = s.mode_en;
        step();
        START = 1'b0; MODE_EN = ~s.mode_en;
        for (int c = 1; c <= 70; c++) begin
            ABORT           = (c == s.abort_at);
            START           = (c == s.busy_start_at);
            BIST_FAIL_VALID = (s.fail_at >= 0) && (c >= s.fail_at) && (c < s.fail_at + s.fail_n);
            BIST_FAIL       = BIST_FAIL_VALID;
            BIST_FAIL_ADDR  = 16'h0100 + 16'(c);
            step();
            if (BIST_EN) obs_en_n++;
            if (BIST_MODE != 3'b000 && BIST_MODE != last_mode) begin
                obs_seq   = {obs_seq[5:0], BIST_MODE};
                last_mode = BIST_MODE;
            end
            if (c == s.abort_at) begin
                chk($sformatf("s%0d abort_en", idx), {31'd0, BIST_EN}, 32'd0);
                chk($sformatf("s%0d abort_mode", idx), {29'd0, BIST_MODE}, 32'd0);
                chk($sformatf("s%0d abort_flag", idx), {31'd0, ABORTED}, 32'd1);
            end
            if (DONE) begin
                obs_done_n++;
                if (obs_done_cyc < 0) begin
                    obs_done_cyc = c; obs_pass = PASS; obs_aborted = ABORTED;
                    obs_fcnt = FAIL_CNT; obs_ffmode = FIRST_FAIL_MODE; obs_ffaddr = FIRST_FAIL_ADDR;
                end
            end
        end
        ABORT = 1'b0; START = 1'b0; BIST_FAIL_VALID = 1'b0; BIST_FAIL = 1'b0;
        chk($sformatf("s%0d done_cycle", idx), obs_done_cyc, s.exp_done);
        chk($sformatf("s%0d done_pulses", idx), obs_done_n, 32'd1);
        chk($sformatf("s%0d en_cycles", idx), obs_en_n, s.exp_en);
        chk($sformatf("s%0d mode_seq", idx), {23'd0, obs_seq}, {23'd0, s.exp_seq});
        chk($sformatf("s%0d pass", idx), {31'd0, obs_pass}, {31'd0, s.exp_pass});
        chk($sformatf("s%0d aborted", idx), {31'd0, obs_aborted}, {31'd0, s.exp_aborted});
        chk($sformatf("s%0d fail_cnt", idx), {28'd0, obs_fcnt}, {28'd0, s.exp_fcnt});
        chk($sformatf("s%0d ff_mode", idx), {29'd0, obs_ffmode}, {29'd0, s.exp_ffmode});
        chk($sformatf("s%0d ff_addr", idx), {16'd0, obs_ffaddr}, {16'd0, s.exp_ffaddr});
        chk($sformatf("s%0d pass_held", idx), {31'd0, PASS}, {31'd0, s.exp_pass});
        chk($sformatf("s%0d busy_idle", idx), {31'd0, BUSY}, 32'd0);
    endtask

    initial begin
        int dn;
        logic busy_seen;
        tbl[0] = '{3'b111, -1,  0, -1, 10, 61, 48, 9'b001_010_100, 1'b1, 1'b0, 4'h0, 3'b000, 16'h0000};
        tbl[1] = '{3'b010, -1,  0, -1, -1, 21, 16, 9'b000_000_010, 1'b1, 1'b0, 4'h0, 3'b000, 16'h0000};
        tbl[2] = '{3'b000, -1,  0, -1, -1,  1,  0, 9'b000_000_000, 1'b1, 1'b0, 4'h0, 3'b000, 16'h0000};
        tbl[3] = '{3'b101, -1,  0, -1, -1, 41, 32, 9'b000_001_100, 1'b1, 1'b0, 4'h0, 3'b000, 16'h0000};
        tbl[4] = '{3'b111, -1,  0,  5, -1,  6,  4, 9'b000_000_001, 1'b0, 1'b1, 4'h0, 3'b000, 16'h0000};
        tbl[5] = '{3'b011, -1,  0, -1, -1, 41, 32, 9'b000_001_010, 1'b1, 1'b0, 4'h0, 3'b000, 16'h0000};
        tbl[6] = '{3'b111,  5, 20, -1, -1, 61, 48, 9'b001_010_100, 1'b0, 1'b0, 4'hF, 3'b001, 16'h0105};

        RST = 1'b1; START = 1'b0; ABORT = 1'b0; MODE_EN = 3'b000;
        BIST_FAIL_VALID = 1'b0; BIST_FAIL = 1'b0; BIST_FAIL_ADDR = 16'h0000;
        step(); step();
        chk("reset_outputs", {BIST_EN, BIST_MODE, BUSY, DONE, PASS, ABORTED, FAIL_CNT,
                              FIRST_FAIL_MODE, FIRST_FAIL_ADDR}, 32'd0);
        RST = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            run_scn(i, tbl[i]);
        end

        // Specific failure events, a VALID-less mismatch and a VALID-only strobe.
        START = 1'b1; MODE_EN = 3'b111;
        step();
        START = 1'b0;
        dn = -1;
        for (int c = 1; c <= 70; c++) begin
            BIST_FAIL_VALID = (c == 25) || (c == 27) || (c == 32) || (c == 45);
            BIST_FAIL       = (c == 25) || (c == 27) || (c == 30) || (c == 45);
            BIST_FAIL_ADDR  = (c == 25) ? 16'h0C05 : (c == 27) ? 16'h0C09 :
                              (c == 45) ? 16'h1234 : 16'hFFFF;
            step();
            if (c == 16) chk("t3_run_last_en", {29'd0, BIST_EN, BIST_MODE[1:0]}, 32'd5);
            if (c == 17) chk("t3_drain_hold", {28'd0, BIST_EN, BIST_MODE}, 32'h1);
            if (c == 21) chk("t3_mode2_start", {28'd0, BIST_EN, BIST_MODE}, 32'hA);
            if (DONE && dn < 0) begin
                dn = c;
                chk("t3_fail_cnt", {28'd0, FAIL_CNT}, 32'd3);
                chk("t3_ff_mode", {29'd0, FIRST_FAIL_MODE}, 32'h2);
                chk("t3_ff_addr", {16'd0, FIRST_FAIL_ADDR}, 32'h0C05);
                chk("t3_pass", {31'd0, PASS}, 32'd0);
            end
        end
        BIST_FAIL_VALID = 1'b0; BIST_FAIL = 1'b0;
        chk("t3_done_cycle", dn, 32'd61);

        // START together with ABORT in IDLE is ignored; results stay put.
        START = 1'b1; ABORT = 1'b1; MODE_EN = 3'b111;
        step();
        START = 1'b0; ABORT = 1'b0;
        busy_seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            busy_seen = busy_seen | BUSY | DONE | BIST_EN;
        end
        chk("start_abort_ignored", {31'd0, busy_seen}, 32'd0);
        chk("start_abort_keep_cnt", {28'd0, FAIL_CNT}, 32'd3);

        // Reset mid-RUN: everything clears and no DONE follows.
        START = 1'b1; MODE_EN = 3'b111;
        step();
        START = 1'b0;
        for (int c = 1; c <= 8; c++) step();
        chk("pre_reset_running", {31'd0, BIST_EN}, 32'd1);
        RST = 1'b1;
        step();
        chk("mid_reset_outputs", {BIST_EN, BIST_MODE, BUSY, DONE, PASS, ABORTED, FAIL_CNT,
                                  FIRST_FAIL_MODE, FIRST_FAIL_ADDR}, 32'd0);
        RST = 1'b0;
        busy_seen = 1'b0;
        for (int c = 0; c < 70; c++) begin
            step();
            busy_seen = busy_seen | DONE | BUSY;
        end
        chk("post_reset_quiet", {31'd0, busy_seen}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
